sdram_port_arbiter: RTL
=======================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 24: word address width of the SDRAM controller slave port.
REQ-002 Parameter DATA_W, default 16: data width of the SDRAM controller slave port.
REQ-003 Parameter MAX_PEND, default 8, power of two >= 2: depth of the outstanding-read tag FIFO.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 m0_address / m1_address  in  ADDR_W  master word address.
REQ-007 m0_read / m1_read  in  1  read request.
REQ-008 m0_write / m1_write  in  1  write request.
REQ-009 m0_writedata / m1_writedata  in  DATA_W  write data.
REQ-010 m0_byteenable / m1_byteenable  in  DATA_W/8  byte enables.
REQ-011 m0_waitrequest / m1_waitrequest  out  1  command not accepted this cycle.
REQ-012 m0_readdata / m1_readdata  out  DATA_W  returned read data.
REQ-013 m0_readdatavalid / m1_readdatavalid  out  1  readdata valid.
REQ-014 s_address, s_read, s_write, s_writedata, s_byteenable  out  widths as master side  forwarded command to the SDRAM controller.
REQ-015 s_waitrequest  in  1;  s_readdata  in  DATA_W;  s_readdatavalid  in  1  SDRAM controller responses.
REQ-016 pend_cnt  out  log2(MAX_PEND)+1  reads issued but not yet returned.
REQ-017 err_orphan  out  1  sticky: read data returned with no read pending.

Function
REQ-018 A master requests when read or write is high; read and write both high on one master is illegal and is treated as a read.
REQ-019 FSM states: IDLE, OWN0, OWN1.
REQ-020 IDLE: with eligible requests, go to OWNi for the winner; with none, stay in IDLE; all s_read/s_write are 0 and all m*_waitrequest are 1.
REQ-021 A read request is eligible only when pend_cnt < MAX_PEND; a write request is always eligible.
REQ-022 Arbitration is round-robin on register last_grant: if both masters are eligible, grant the master not in last_grant; if one is eligible, grant it; last_grant updates on entry to OWNi.
REQ-023 OWNi: the owner's address, read, write, writedata and byteenable drive s_* combinationally; owner waitrequest = s_waitrequest; non-owner waitrequest = 1.
REQ-024 In OWNi, the command is accepted in the cycle where the owner requests and s_waitrequest = 0; next state is IDLE, giving 1 cycle of arbitration per command.
REQ-025 In OWNi, if the owner deasserts its request before acceptance (protocol violation), return to IDLE with no command issued.
REQ-026 On an accepted read, push the owner ID into the tag FIFO and increment pend_cnt.
REQ-027 On s_readdatavalid with pend_cnt > 0, pop the FIFO head; for that cycle only, assert readdatavalid to the head-ID master with readdata = s_readdata; decrement pend_cnt.
REQ-028 On s_readdatavalid with pend_cnt = 0, drop the data, leave pend_cnt unchanged, and set err_orphan; err_orphan clears only on reset.
REQ-029 Push and pop in the same cycle: pend_cnt is unchanged and both FIFO pointers advance; this is legal when the FIFO is full.
REQ-030 FIFO pointers wrap modulo MAX_PEND; read data returns in issue order.
REQ-031 Response routing is independent of the FSM state; a response is delivered while another command is in progress.
REQ-032 m*_readdata equals s_readdata unconditionally; only readdatavalid is steered.

Reset
REQ-033 While reset_n = 0: state = IDLE, last_grant = 1 (m0 wins the first tie), pend_cnt = 0, FIFO pointers = 0, err_orphan = 0, s_read = s_write = 0, m*_waitrequest = 1, m*_readdatavalid = 0.
REQ-034 Reset mid-operation discards all pending reads; later s_readdatavalid pulses count as orphans.

Verification
REQ-035 After reset, m0 and m1 both assert read on the same cycle with s_waitrequest = 0 -> m0 is issued first, then m1; s_read is high for 1 cycle per grant; pend_cnt goes 1 then 2.
REQ-036 Both masters issue continuous writes -> grants alternate 0,1,0,1; neither master waits more than 4 cycles.
REQ-037 m1 issues 8 reads with no responses (MAX_PEND = 8) -> the 9th m1 read is held (waitrequest = 1) while an m0 write is still granted; 1 response -> the 9th read issues.
REQ-038 Reads issued m0, m1, m0, then 3 s_readdatavalid pulses with data 0x1111, 0x2222, 0x3333 -> m0 gets 0x1111, m1 gets 0x2222, m0 gets 0x3333.
REQ-039 pend_cnt = 8 with a read accept and s_readdatavalid in the same cycle -> pend_cnt stays 8 and ordering is preserved.
REQ-040 s_readdatavalid with pend_cnt = 0, including right after a reset mid-read -> no master readdatavalid and err_orphan = 1.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin two-master arbiter onto one SDRAM slave port with in-order read tag routing
module sdram_port_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDR_W-1:0]         m0_address,
  input  logic                      m0_read,
  input  logic                      m0_write,
  input  logic [DATA_W-1:0]         m0_writedata,
  input  logic [DATA_W/8-1:0]       m0_byteenable,
  output logic                      m0_waitrequest,
  output logic [DATA_W-1:0]         m0_readdata,
  output logic                      m0_readdatavalid,
  input  logic [ADDR_W-1:0]         m1_address,
  input  logic                      m1_read,
  input  logic                      m1_write,
  input  logic [DATA_W-1:0]         m1_writedata,
  input  logic [DATA_W/8-1:0]       m1_byteenable,
  output logic                      m1_waitrequest,
  output logic [DATA_W-1:0]         m1_readdata,
  output logic                      m1_readdatavalid,
  output logic [ADDR_W-1:0]         s_address,
  output logic                      s_read,
  output logic                      s_write,
  output logic [DATA_W-1:0]         s_writedata,
  output logic [DATA_W/8-1:0]       s_byteenable,
  input  logic                      s_waitrequest,
  input  logic [DATA_W-1:0]         s_readdata,
  input  logic                      s_readdatavalid,
  output logic [$clog2(MAX_PEND):0] pend_cnt,
  output logic                      err_orphan
);
  localparam int PW = $clog2(MAX_PEND);
  localparam logic [PW:0] FULL = (PW+1)'(MAX_PEND);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, state_nx;
  logic last_grant, room, elig0, elig1, own0, own1, rd_own, req_own, push, pop;
  logic [MAX_PEND-1:0] tags;
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign room  = pend_cnt < FULL;
  assign elig0 = m0_read ? room : m0_write;
  assign elig1 = m1_read ? room : m1_write;
  assign own0  = state == OWN0;
  assign own1  = state == OWN1;
  always_comb begin
    state_nx       = state;
    rd_own         = own0 ? m0_read : own1 ? m1_read : 1'b0;
    req_own        = own0 ? (m0_read | m0_write) : own1 ? (m1_read | m1_write) : 1'b0;
    s_read         = rd_own;
    s_write        = req_own & ~rd_own;
    s_address      = own1 ? m1_address : m0_address;
    s_writedata    = own1 ? m1_writedata : m0_writedata;
    s_byteenable   = own1 ? m1_byteenable : m0_byteenable;
    m0_waitrequest = own0 ? s_waitrequest : 1'b1;
    m1_waitrequest = own1 ? s_waitrequest : 1'b1;
    state_nx       = state == IDLE ? ((elig0 & elig1) ? (last_grant ? OWN0 : OWN1) :
                                      elig0 ? OWN0 : elig1 ? OWN1 : IDLE) :
                     (req_own & s_waitrequest) ? state : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) last_grant <= state_nx == OWN1;
    end
  assign push = rd_own & ~s_waitrequest;
  assign pop  = s_readdatavalid & (pend_cnt != '0);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tags       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pend_cnt   <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) tags[wr_ptr] <= own1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      pend_cnt   <= pend_cnt + (PW+1)'(push) - (PW+1)'(pop);
      err_orphan <= err_orphan | (s_readdatavalid & (pend_cnt == '0));
    end
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = pop & ~tags[rd_ptr];
  assign m1_readdatavalid = pop & tags[rd_ptr];
endmodule
